// File: rtl/tlc1543_scan_sched.sv
// TLC1543 scan scheduler: periodic ascending channel walk with the
// ADC's one-transfer result lag, a flush transfer and a result bank.
module tlc1543_scan_sched #(
   parameter int CH_NUM      = 11,
   parameter int PERIOD_CYC  = 50000,
   parameter int TIMEOUT_CYC = 4096,
   parameter int FLUSH_ADDR  = 11
) (
   input  logic              clk_50m,
   input  logic              rst,
   input  logic              scan_en,
   input  logic [CH_NUM-1:0] ch_mask,
   output logic              conv_start,
   output logic [3:0]        conv_ch,
   input  logic              conv_done,
   input  logic [9:0]        conv_data,
   input  logic [3:0]        rd_ch,
   output logic [9:0]        rd_data,
   output logic [CH_NUM-1:0] data_valid,
   output logic              busy,
   output logic              scan_done,
   output logic              timeout_err,
   output logic              overrun_err,
   input  logic              err_clr
);

   localparam int PW = $clog2(PERIOD_CYC);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_STORE, S_FLUSH, S_FWAIT
   } state_t;

   state_t            r_state;
   logic [PW-1:0]     r_per;
   logic [TW-1:0]     r_to;
   logic [CH_NUM-1:0] r_mask;
   logic [3:0]        r_prev_ch;
   logic              r_prev_v;
   logic [9:0]        r_cdata;
   logic [9:0]        r_bank [CH_NUM];
   logic              w_tick;

   function automatic logic [3:0] f_low(input logic [CH_NUM-1:0] m);
      f_low = '0;
      for (int i = CH_NUM - 1; i >= 0; i--)
         if (m[i]) f_low = 4'(i);
   endfunction

   assign w_tick = scan_en && (r_per == PW'(PERIOD_CYC - 1));

   always_ff @(posedge clk_50m) begin
      if (rst || !scan_en) r_per <= '0;
      else if (w_tick)     r_per <= '0;
      else                 r_per <= r_per + PW'(1);
   end

   // ISSUE/FLUSH are the cycles in which the registered conv_start is high
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_to        <= '0;
         r_mask      <= '0;
         r_prev_ch   <= '0;
         r_prev_v    <= 1'b0;
         r_cdata     <= '0;
         r_bank      <= '{default: '0};
         conv_start  <= 1'b0;
         conv_ch     <= '0;
         data_valid  <= '0;
         busy        <= 1'b0;
         scan_done   <= 1'b0;
         timeout_err <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         conv_start <= 1'b0;
         scan_done  <= 1'b0;
         if (err_clr) begin
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
         end
         if (w_tick && busy) overrun_err <= 1'b1;
         unique case (r_state)
            S_IDLE: begin
               if (w_tick && (|ch_mask)) begin
                  r_mask     <= ch_mask & (ch_mask - CH_NUM'(1));
                  conv_ch    <= f_low(ch_mask);
                  conv_start <= 1'b1;
                  busy       <= 1'b1;
                  r_state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_to    <= TW'(1);
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (conv_done) begin
                  r_cdata <= conv_data;
                  r_state <= S_STORE;
               end else if (r_to == TW'(TIMEOUT_CYC - 1)) begin
                  timeout_err <= 1'b1;
                  busy        <= 1'b0;
                  r_prev_v    <= 1'b0;
                  r_state     <= S_IDLE;
               end else begin
                  r_to <= r_to + TW'(1);
               end
            end
            S_STORE: begin
               if (r_prev_v) begin
                  r_bank[r_prev_ch]     <= r_cdata;
                  data_valid[r_prev_ch] <= 1'b1;
               end
               r_prev_ch  <= conv_ch;
               r_prev_v   <= 1'b1;
               conv_start <= 1'b1;
               if (|r_mask) begin
                  conv_ch <= f_low(r_mask);
                  r_mask  <= r_mask & (r_mask - CH_NUM'(1));
                  r_state <= S_ISSUE;
               end else begin
                  conv_ch <= 4'(FLUSH_ADDR);
                  r_state <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               r_to    <= TW'(1);
               r_state <= S_FWAIT;
            end
            S_FWAIT: begin
               if (conv_done) begin
                  if (r_prev_v) begin
                     r_bank[r_prev_ch]     <= conv_data;
                     data_valid[r_prev_ch] <= 1'b1;
                  end
                  r_prev_v  <= 1'b0;
                  busy      <= 1'b0;
                  scan_done <= 1'b1;
                  r_state   <= S_IDLE;
               end else if (r_to == TW'(TIMEOUT_CYC - 1)) begin
                  timeout_err <= 1'b1;
                  busy        <= 1'b0;
                  r_prev_v    <= 1'b0;
                  r_state     <= S_IDLE;
               end else begin
                  r_to <= r_to + TW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_50m) begin
      if (rst)                      rd_data <= '0;
      else if (rd_ch < 4'(CH_NUM))  rd_data <= r_bank[rd_ch];
      else                          rd_data <= '0;
   end

endmodule

// File: doc/tlc1543_scan_sched.md
Name: tlc1543_scan_sched

Overview:
Scan scheduler for the TLC1543 11-channel 10-bit serial ADC. It sits between system logic and the TLC1543 serial-transfer engine, which is driven by a conv_start/conv_done handshake. On each sample-period tick it walks the enabled channels in ascending order. It also handles the ADC's one-transfer result pipeline: each transfer returns the previous address's conversion. Results go into an 11-entry result bank with a registered read port.

Parameters:
CH_NUM, 11, number of analog channels (addresses 0..CH_NUM-1)
PERIOD_CYC, 50000, scan period in clk_50m cycles (1 ms)
TIMEOUT_CYC, 4096, maximum clk_50m cycles from conv_start to conv_done
FLUSH_ADDR, 11, address used for the flush transfer ((Vref+ - Vref-)/2 self-test)

Ports:
clk_50m  in  1  system clock; the only clock
rst  in  1  synchronous active-high reset
scan_en  in  1  enables periodic scanning
ch_mask  in  CH_NUM  per-channel enable; snapshotted at scan start
conv_start  out  1  one-cycle pulse that requests a transfer from the engine
conv_ch  out  4  address for the requested transfer; stable from conv_start until conv_done
conv_done  in  1  one-cycle pulse from the engine at end of transfer
conv_data  in  10  transfer result; valid in the conv_done cycle
rd_ch  in  4  result bank read address
rd_data  out  10  bank[rd_ch], registered
data_valid  out  CH_NUM  bit n set once channel n has stored a result
busy  out  1  high from scan start until scan end or abort
scan_done  out  1  one-cycle pulse on scan completion
timeout_err  out  1  sticky: conv_done did not arrive within TIMEOUT_CYC
overrun_err  out  1  sticky: a tick arrived while busy
err_clr  in  1  clears timeout_err and overrun_err

Behaviour:
- Reset values: all outputs 0; bank entries 0; FSM in IDLE; period counter 0; prev_valid 0.
- Period counter:
  - Counts 0..PERIOD_CYC-1 while scan_en=1; wraps to 0.
  - tick=1 in the cycle the counter equals PERIOD_CYC-1.
  - When scan_en=0 the counter is held at 0.
- FSM states: IDLE, ISSUE, WAIT_DONE, STORE, FLUSH, FLUSH_WAIT.
- IDLE:
  - On tick with ch_mask != 0: snapshot the mask into mask_q, set busy, go to ISSUE.
  - On tick with ch_mask == 0: ignore the tick.
- ISSUE:
  - Select the lowest set bit of mask_q; drive conv_ch to that address; pulse conv_start; clear that mask_q bit; go to WAIT_DONE.
  - Latency: conv_start is asserted 1 cycle after the tick.
- WAIT_DONE:
  - Timeout counter increments each cycle.
  - On conv_done, go to STORE.
  - If the counter reaches TIMEOUT_CYC, set timeout_err, clear busy and prev_valid, go to IDLE. Nothing is stored and scan_done does not pulse.
- STORE:
  - If prev_valid: write bank[prev_ch] <= conv_data and set data_valid[prev_ch].
  - Then prev_ch <= conv_ch and prev_valid <= 1.
  - If mask_q != 0, go to ISSUE. The next conv_start comes 2 cycles after conv_done.
  - Otherwise go to FLUSH.
- FLUSH:
  - Pulse conv_start with conv_ch=FLUSH_ADDR; go to FLUSH_WAIT.
- FLUSH_WAIT:
  - Same timeout rule as WAIT_DONE.
  - On conv_done: store conv_data to bank[prev_ch], clear prev_valid and busy, pulse scan_done, go to IDLE.
  - The flush address's own conversion is never stored.
- The first transfer of every scan stores nothing (prev_valid=0 at scan start).
- conv_done outside WAIT_DONE or FLUSH_WAIT is ignored.
- Simultaneous events:
  - A tick while busy sets overrun_err and is otherwise ignored.
  - If err_clr and an error-set event occur in the same cycle, the set wins.
- scan_en deasserted mid-scan: the current scan finishes, including the flush; no new scan starts.
- rst mid-scan: immediate return to reset state; conv_start is not asserted in the cycle after rst.
- Read port:
  - rd_data <= bank[rd_ch] each cycle, so data appears 1 cycle after rd_ch.
  - rd_ch >= CH_NUM returns 0.
  - A same-cycle write to the entry being read returns the old value.

Test Plan:
- PERIOD_CYC=100, ch_mask=11'h005, engine model returns 10*(addr+1) one transfer late. Required: conv_ch sequence 0, 2, 11; bank[0]=10, bank[2]=30; data_valid=11'h005; scan_done 1 cycle after the third conv_done; next conv_start on the following tick.
- ch_mask=11'h400. Required: two transfers (addr 10, then 11); bank[10] is the value returned by the flush transfer.
- Engine never answers, TIMEOUT_CYC=16. Required: timeout_err=1 exactly 16 cycles after conv_start; busy=0; no scan_done; the next tick restarts the scan from the lowest mask bit.
- Engine latency of 150 cycles with PERIOD_CYC=100. Required: overrun_err=1; the scan still completes; err_clr clears the flag.
- ch_mask=0, scan_en=1. Required: no conv_start over 5 periods. Separately, scan_en dropped during a scan: the scan completes and no further scans start.
- rst asserted between conv_start and conv_done. Required: all outputs 0 next cycle; a later conv_done is ignored; bank reads return 0.
